tlu_rx: RTL and testbench
=========================

Name: tlu_rx

Overview:
- DUT-side endpoint of the TLU trigger/busy/clock handshake.
- Detects a trigger on TLU_TRIGGER and asserts TLU_BUSY.
- Generates TLU_CLOCK pulses to shift the 15-bit trigger ID in serially over TLU_TRIGGER, then presents the ID on a valid/ready interface.
- Sits between the TLU cable pins and the DUT readout/trigger logic.

Parameters:
INV_IN, 0, invert TLU_TRIGGER/TLU_RESET inputs and TLU_CLOCK/TLU_BUSY outputs (cable polarity swap)
ID_BITS, 15, trigger ID width

Ports:
SYS_CLK  in  1  system clock; single clock domain
SYS_RST  in  1  synchronous, active-high reset
ENABLE  in  1  accept new triggers when high
CONF_CLK_HALF  in  8  TLU_CLOCK half period in SYS_CLK cycles; values <4 treated as 4
TLU_TRIGGER  in  1  async trigger line; also carries serial ID bits
TLU_RESET  in  1  async; a rising edge clears counters
TLU_CLOCK  out  1  ID shift clock to TLU
TLU_BUSY  out  1  busy/handshake to TLU
TRIG_PULSE  out  1  one-cycle pulse on accepted trigger
ID_DATA  out  ID_BITS  received trigger ID
ID_VALID  out  1  ID_DATA valid
ID_READY  in  1  consumer accepts ID
ID_MISMATCH  out  1  qualified by ID_VALID; ID differs from expected
TRIG_CNT  out  32  accepted-trigger counter

Behaviour:
- Input synchronisation and edge detection:
  - TLU_TRIGGER and TLU_RESET pass through 2-FF synchronisers, with inversion applied per INV_IN.
  - Edge detection uses the synchronised signal versus a 1-cycle delayed copy.
- Output registering:
  - TLU_CLOCK and TLU_BUSY are driven directly from flops; no combinational paths.
  - INV_IN inverts them at the flop output.
- Reset values: TLU_CLOCK=0, TLU_BUSY=0 (logical, before inversion), TRIG_PULSE=0, ID_VALID=0, ID_DATA=0, ID_MISMATCH=0, TRIG_CNT=0, expected ID=0, state=IDLE, armed=1.
- FSM states: IDLE, SETTLE, CLK_HI, CLK_LO, OUTPUT, REARM.
- IDLE:
  - Trigger condition: synced trigger rising edge && ENABLE && armed.
  - On trigger: TRIG_PULSE=1 for one cycle, TRIG_CNT+=1 (wraps at 2^32), TLU_BUSY<=1, bit counter k<=0, go to SETTLE.
  - With ENABLE=0, triggers are ignored and no BUSY is raised.
- SETTLE: hold TLU_CLOCK=0 for CONF_CLK_HALF cycles, then go to CLK_HI.
- CLK_HI:
  - TLU_CLOCK=1 for H cycles, where H = max(CONF_CLK_HALF, 4); then k+=1 and go to CLK_LO.
- CLK_LO:
  - TLU_CLOCK=0 for H cycles.
  - On the last cycle, if k<=ID_BITS, sample the synced line into the ID shift register: shift right, new bit enters the MSB. After ID_BITS samples, bit 0 holds the bit sent after clock edge 1.
  - If k==ID_BITS+1, go to OUTPUT; else go to CLK_HI.
  - Total: ID_BITS+1 clock pulses; the last pulse flushes the transmitter's shift register.
- OUTPUT:
  - ID_VALID=1 and ID_DATA stable.
  - ID_MISMATCH = (ID_DATA != expected[ID_BITS-1:0]).
  - TLU_BUSY stays 1 while ID_READY=0; this is backpressure, so the TLU cannot issue a new trigger.
  - On ID_VALID&&ID_READY: ID_VALID<=0, TLU_BUSY<=0, expected<=ID_DATA+1 (wraps modulo 2^ID_BITS, which resyncs after a mismatch), go to REARM.
- REARM:
  - Wait until synced TLU_TRIGGER==0, then go to IDLE.
  - This prevents a stuck-high line from being re-detected.
- TLU_RESET rising edge (synced):
  - Clears TRIG_CNT and expected to 0 on the next cycle.
  - The FSM is unaffected.
  - If it coincides with a trigger accept, the clear wins and TRIG_CNT=0.
- SYS_RST mid-transaction: all outputs go to reset values on the next edge; TLU_BUSY and TLU_CLOCK drop immediately.
- ENABLE dropping mid-transaction: the transaction completes normally.
- CONF_CLK_HALF is sampled at trigger accept and held for the whole transaction.
- Latency:
  - TLU_BUSY rises 4 SYS_CLK cycles after TLU_TRIGGER rises at the pin (2 sync + edge + register).
  - ID_VALID rises H + (ID_BITS+1)·2H cycles after TLU_BUSY.

Decomposition:
- Shared package tlu_pkg: state encoding localparams, ID_BITS default, minimum half period (4).
- One sub-module tlu_rx_sync: 2-FF synchroniser with optional inversion, reused for TLU_TRIGGER and TLU_RESET.

Test Plan:
- Basic ID transfer:
  - Stimulus: transmitter model sends ID 0x1234, H=4, ID_READY=1.
  - Required: TLU_BUSY high 4 cycles after trigger; exactly 16 TLU_CLOCK pulses; ID_DATA=0x1234; ID_MISMATCH=1 (expected 0); TRIG_CNT=1; BUSY low 1 cycle after handshake.
- In-sequence IDs:
  - Stimulus: IDs 0,1,2 sent back-to-back.
  - Required: ID_MISMATCH=0 each time; TRIG_CNT=3.
- Backpressure:
  - Stimulus: ID_READY=0 for 50 cycles after ID_VALID.
  - Required: TLU_BUSY and ID_VALID held and ID_DATA stable; a second trigger pulse during this window is ignored; TRIG_CNT unchanged.
- Maximum ID with minimum half period:
  - Stimulus: ID 0x7FFF; CONF_CLK_HALF=2.
  - Required: H clamps to 4, so each pulse is 4 high / 4 low; ID_DATA=0x7FFF.
- Enable, re-arm and counter reset:
  - Stimulus: trigger with ENABLE=0, then trigger line held high after the transfer, then TLU_RESET pulse.
  - Required: no BUSY for the disabled trigger; no retrigger until the line returns low; TRIG_CNT=0 and next expected ID=0 after the reset.
- Reset mid-shift:
  - Stimulus: SYS_RST asserted during the 7th clock pulse.
  - Required: TLU_CLOCK=0, TLU_BUSY=0, ID_VALID=0 next cycle; a following trigger completes normally.
- Polarity: rerun the basic ID transfer with INV_IN=1 and inverted pins; required: identical logical results.

Source files
------------

// File: rtl/tlu_pkg.sv
// tlu_pkg: shared types and constants for the TLU trigger/busy/clock receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tlu_pkg;

   localparam int         ID_BITS_DEF = 15;     // trigger ID width used by the TLU
   localparam logic [7:0] MIN_HALF    = 8'd4;   // shortest TLU_CLOCK half period in SYS_CLK cycles

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_CLK_HI = 3'd2,
      ST_CLK_LO = 3'd3,
      ST_OUTPUT = 3'd4,
      ST_REARM  = 3'd5
   } state_t;

   // Half periods below MIN_HALF leave too little room for the 2-FF input
   // synchroniser to see the returned bit before it is sampled.
   function automatic logic [7:0] clamp_half(input logic [7:0] conf);
      return (conf < MIN_HALF) ? MIN_HALF : conf;
   endfunction

endpackage

// File: rtl/tlu_rx_sync.sv
// tlu_rx_sync: 2-FF synchroniser for an asynchronous TLU cable input, with optional polarity swap.
// Latency: 2 clk cycles from pin to dout.
// Backpressure: none.
// Ports: clk/rst (sync, active high), din (async pin), dout (synchronised, logical polarity).
module tlu_rx_sync #(
   parameter bit INV = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   import tlu_pkg::*;

   logic meta;
   logic stable;

   // Inversion happens ahead of the first flop so everything downstream
   // works in logical polarity regardless of cable wiring.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         stable <= 1'b0;
      end else begin
         meta   <= din ^ INV;
         stable <= meta;
      end
   end

   assign dout = stable;

endmodule

// File: rtl/tlu_rx.sv
// tlu_rx: DUT-side TLU endpoint; accepts a trigger, raises BUSY, clocks in the serial trigger ID.
// Latency: BUSY rises 4 cycles after the TRIGGER pin; ID_VALID rises H + (ID_BITS+1)*2H cycles after BUSY.
// Backpressure: ID_VALID/ID_DATA hold until ID_READY; BUSY stays high meanwhile so the TLU cannot retrigger.
// Ports: SYS_CLK/SYS_RST (sync, active high); ENABLE, CONF_CLK_HALF config; TLU_TRIGGER/TLU_RESET
//        cable inputs, TLU_CLOCK/TLU_BUSY cable outputs; TRIG_PULSE, TRIG_CNT status;
//        ID_DATA/ID_VALID/ID_READY/ID_MISMATCH received-ID valid/ready interface.
module tlu_rx
   import tlu_pkg::*;
#(
   parameter bit INV_IN  = 1'b0,
   parameter int ID_BITS = ID_BITS_DEF
) (
   input  logic               SYS_CLK,
   input  logic               SYS_RST,
   input  logic               ENABLE,
   input  logic [7:0]         CONF_CLK_HALF,
   input  logic               TLU_TRIGGER,
   input  logic               TLU_RESET,
   output logic               TLU_CLOCK,
   output logic               TLU_BUSY,
   output logic               TRIG_PULSE,
   output logic [ID_BITS-1:0] ID_DATA,
   output logic               ID_VALID,
   input  logic               ID_READY,
   output logic               ID_MISMATCH,
   output logic [31:0]        TRIG_CNT
);

   localparam int            KW     = $clog2(ID_BITS + 2);
   localparam logic [KW-1:0] K_LAST = KW'(ID_BITS);       // last pulse whose bit is sampled
   localparam logic [KW-1:0] K_END  = KW'(ID_BITS + 1);   // extra pulse flushes the TLU shifter

   logic trig_s, trig_d, trig_edge;
   logic rst_s, rst_d, rst_edge;

   state_t             state, state_n;
   logic [7:0]         cnt, cnt_n;
   logic [7:0]         half, half_n;
   logic [KW-1:0]      k, k_n;
   logic               armed, armed_n;
   logic               clk_q, clk_n;
   logic               busy_q, busy_n;
   logic               pulse_q, pulse_n;
   logic               valid_q, valid_n;
   logic [ID_BITS-1:0] data_q, data_n;
   logic [ID_BITS-1:0] exp_q, exp_n;
   logic [31:0]        trig_cnt_q, trig_cnt_n;
   logic               cnt_last;

   tlu_rx_sync #(.INV(INV_IN)) u_sync_trig (
      .clk  (SYS_CLK),
      .rst  (SYS_RST),
      .din  (TLU_TRIGGER),
      .dout (trig_s)
   );

   tlu_rx_sync #(.INV(INV_IN)) u_sync_rst (
      .clk  (SYS_CLK),
      .rst  (SYS_RST),
      .din  (TLU_RESET),
      .dout (rst_s)
   );

   assign cnt_last = (cnt == half - 8'd1);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      half_n     = half;
      k_n        = k;
      armed_n    = armed;
      clk_n      = clk_q;
      busy_n     = busy_q;
      pulse_n    = 1'b0;
      valid_n    = valid_q;
      data_n     = data_q;
      exp_n      = exp_q;
      trig_cnt_n = trig_cnt_q;

      case (state)
         ST_IDLE: begin
            if (trig_edge && ENABLE && armed) begin
               pulse_n    = 1'b1;
               trig_cnt_n = trig_cnt_q + 32'd1;
               busy_n     = 1'b1;
               k_n        = '0;
               cnt_n      = '0;
               half_n     = clamp_half(CONF_CLK_HALF);  // frozen for the whole transaction
               armed_n    = 1'b0;
               state_n    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_last) begin
               cnt_n   = '0;
               clk_n   = 1'b1;
               state_n = ST_CLK_HI;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_CLK_HI: begin
            if (cnt_last) begin
               cnt_n   = '0;
               clk_n   = 1'b0;
               k_n     = k + 1'b1;
               state_n = ST_CLK_LO;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_CLK_LO: begin
            if (cnt_last) begin
               cnt_n = '0;
               // Sample as late as possible so the bit has crossed the synchroniser.
               if (k <= K_LAST) begin
                  data_n = {trig_s, data_q[ID_BITS-1:1]};
               end
               if (k == K_END) begin
                  valid_n = 1'b1;
                  state_n = ST_OUTPUT;
               end else begin
                  clk_n   = 1'b1;
                  state_n = ST_CLK_HI;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_OUTPUT: begin
            if (ID_READY) begin
               valid_n = 1'b0;
               busy_n  = 1'b0;
               exp_n   = data_q + 1'b1;   // resyncs to the received ID after a mismatch
               state_n = ST_REARM;
            end
         end
         ST_REARM: begin
            // A line stuck high must not count as a fresh trigger.
            if (!trig_s) begin
               armed_n = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Counter clear takes priority over a coincident trigger accept.
      if (rst_edge) begin
         trig_cnt_n = '0;
         exp_n      = '0;
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         trig_d     <= 1'b0;
         trig_edge  <= 1'b0;
         rst_d      <= 1'b0;
         rst_edge   <= 1'b0;
         state      <= ST_IDLE;
         cnt        <= '0;
         half       <= MIN_HALF;
         k          <= '0;
         armed      <= 1'b1;
         clk_q      <= 1'b0;
         busy_q     <= 1'b0;
         pulse_q    <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         exp_q      <= '0;
         trig_cnt_q <= '0;
      end else begin
         trig_d     <= trig_s;
         trig_edge  <= trig_s & ~trig_d;
         rst_d      <= rst_s;
         rst_edge   <= rst_s & ~rst_d;
         state      <= state_n;
         cnt        <= cnt_n;
         half       <= half_n;
         k          <= k_n;
         armed      <= armed_n;
         clk_q      <= clk_n;
         busy_q     <= busy_n;
         pulse_q    <= pulse_n;
         valid_q    <= valid_n;
         data_q     <= data_n;
         exp_q      <= exp_n;
         trig_cnt_q <= trig_cnt_n;
      end
   end

   assign TLU_CLOCK   = clk_q ^ INV_IN;
   assign TLU_BUSY    = busy_q ^ INV_IN;
   assign TRIG_PULSE  = pulse_q;
   assign ID_DATA     = data_q;
   assign ID_VALID    = valid_q;
   assign ID_MISMATCH = valid_q && (data_q != exp_q);
   assign TRIG_CNT    = trig_cnt_q;

endmodule

// File: tb/tb_tlu_rx.sv
// tb_tlu_rx: directed scoreboard bench for tlu_rx; a normal-polarity and an inverted-polarity
// instance run in lockstep from the same stimulus, and a TLU transmitter model answers TLU_CLOCK.
module tb_tlu_rx;

   typedef struct packed {
      logic [14:0] id;
      logic        mism;
   } exp_t;

   logic        SYS_CLK = 1'b0;
   logic        SYS_RST;
   logic        ENABLE;
   logic [7:0]  CONF_CLK_HALF;
   logic        TLU_TRIGGER;
   logic        TLU_RESET;
   logic        ID_READY;

   logic        tlu_clock, tlu_busy, trig_pulse, id_valid, id_mismatch;
   logic [14:0] id_data;
   logic [31:0] trig_cnt;

   logic        trig_inv, reset_inv;
   logic        tlu_clock_i, tlu_busy_i, trig_pulse_i, id_valid_i, id_mismatch_i;
   logic [14:0] id_data_i;
   logic [31:0] trig_cnt_i;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pulses = 0;
   int   pol_bad  = 0;
   int   p0, bp_bad, busy_seen;
   exp_t sb[$];
   exp_t mon_e;

   assign trig_inv  = ~TLU_TRIGGER;
   assign reset_inv = ~TLU_RESET;

   tlu_rx #(.INV_IN(1'b0), .ID_BITS(15)) u_dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE), .CONF_CLK_HALF(CONF_CLK_HALF),
      .TLU_TRIGGER(TLU_TRIGGER), .TLU_RESET(TLU_RESET), .TLU_CLOCK(tlu_clock), .TLU_BUSY(tlu_busy),
      .TRIG_PULSE(trig_pulse), .ID_DATA(id_data), .ID_VALID(id_valid), .ID_READY(ID_READY),
      .ID_MISMATCH(id_mismatch), .TRIG_CNT(trig_cnt)
   );

   tlu_rx #(.INV_IN(1'b1), .ID_BITS(15)) u_dut_inv (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .ENABLE(ENABLE), .CONF_CLK_HALF(CONF_CLK_HALF),
      .TLU_TRIGGER(trig_inv), .TLU_RESET(reset_inv), .TLU_CLOCK(tlu_clock_i), .TLU_BUSY(tlu_busy_i),
      .TRIG_PULSE(trig_pulse_i), .ID_DATA(id_data_i), .ID_VALID(id_valid_i), .ID_READY(ID_READY),
      .ID_MISMATCH(id_mismatch_i), .TRIG_CNT(trig_cnt_i)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge SYS_CLK);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) step();
   endtask

   // Monitor: pops the scoreboard on every ID handshake, counts trigger pulses and
   // checks the inverted instance tracks the normal one pin for pin.
   always @(negedge SYS_CLK) begin
      if (trig_pulse === 1'b1) n_pulses++;
      if ({tlu_clock_i, tlu_busy_i} !== ~{tlu_clock, tlu_busy} ||
          {trig_pulse_i, id_valid_i, id_mismatch_i} !== {trig_pulse, id_valid, id_mismatch} ||
          id_data_i !== id_data || trig_cnt_i !== trig_cnt)
         pol_bad++;
      if (id_valid === 1'b1 && ID_READY && !SYS_RST) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("id_data", 32'(id_data), 32'(mon_e.id));
            chk("id_mismatch", 32'(id_mismatch), 32'(mon_e.mism));
            chk("id_data_inv", 32'(id_data_i), 32'(mon_e.id));
         end
      end
   end

   // Transmitter model: raise TRIGGER, wait for BUSY, then put ID bit j-1 on the line at the
   // rising edge of TLU_CLOCK pulse j. Measures high/low widths against hexp.
   task automatic send_id(input logic [14:0] id, input logic mism, input int hexp,
                          input logic [7:0] conf_mid, input logic hold_high,
                          input int abort_at, input logic rdy);
      int   lat, np, bad, hi, lo, guard, pc;
      logic prev, aborted;
      ID_READY = rdy;
      pc = n_pulses;
      if (abort_at == 0) sb.push_back('{id: id, mism: mism});
      TLU_TRIGGER = 1'b1;
      lat = 0;
      do begin
         step();
         lat++;
      end while (!tlu_busy && lat < 20);
      chk("busy_latency", lat, 4);
      CONF_CLK_HALF = conf_mid;
      np = 0; bad = 0; hi = 0; lo = 0; guard = 0; prev = 1'b0; aborted = 1'b0;
      while (!id_valid && guard < 3000) begin
         step();
         guard++;
         if (tlu_clock && !prev) begin
            np++;
            if (np > 1 && lo != hexp) bad++;
            hi = 1;
            TLU_TRIGGER = (np <= 15) ? id[np-1] : hold_high;
            if (abort_at != 0 && np == abort_at) begin
               SYS_RST = 1'b1;
               TLU_TRIGGER = 1'b0;
               step();
               chk("rst_clock", 32'(tlu_clock), 32'd0);
               chk("rst_busy", 32'(tlu_busy), 32'd0);
               chk("rst_valid", 32'(id_valid), 32'd0);
               chk("rst_trig_cnt", trig_cnt, 32'd0);
               SYS_RST = 1'b0;
               aborted = 1'b1;
               break;
            end
         end else if (tlu_clock) begin
            hi++;
         end else if (prev) begin
            if (hi != hexp) bad++;
            lo = 1;
         end else begin
            lo++;
         end
         prev = tlu_clock;
      end
      chk("trig_pulse_count", n_pulses - pc, 1);
      if (!aborted) begin
         chk("id_valid_seen", 32'(id_valid), 32'd1);
         chk("clock_pulses", np, 16);
         chk("clock_width_errors", bad, 0);
         if (rdy) begin
            step();
            chk("busy_drop", 32'(tlu_busy), 32'd0);
            chk("valid_drop", 32'(id_valid), 32'd0);
         end
      end
   endtask

   task automatic tlu_reset_pulse();
      TLU_RESET = 1'b1;
      gap(3);
      TLU_RESET = 1'b0;
      gap(3);
   endtask

   initial begin
      SYS_RST = 1'b1; ENABLE = 1'b1; TLU_TRIGGER = 1'b0; TLU_RESET = 1'b0;
      ID_READY = 1'b1; CONF_CLK_HALF = 8'd4;
      gap(3);
      chk("reset_clock", 32'(tlu_clock), 32'd0);
      chk("reset_busy", 32'(tlu_busy), 32'd0);
      chk("reset_pulse", 32'(trig_pulse), 32'd0);
      chk("reset_valid", 32'(id_valid), 32'd0);
      chk("reset_data", 32'(id_data), 32'd0);
      chk("reset_mismatch", 32'(id_mismatch), 32'd0);
      chk("reset_trig_cnt", trig_cnt, 32'd0);
      SYS_RST = 1'b0;
      gap(3);

      // Basic transfer: expected ID is 0, so 0x1234 is flagged.
      send_id(15'h1234, 1'b1, 4, 8'd4, 1'b0, 0, 1'b1);
      chk("basic_trig_cnt", trig_cnt, 32'd1);
      gap(5);

      tlu_reset_pulse();
      chk("tlu_reset_cnt", trig_cnt, 32'd0);

      // In-sequence IDs 0,1,2 with H=5.
      CONF_CLK_HALF = 8'd5;
      for (int i = 0; i < 3; i++) begin
         send_id(15'(i), 1'b0, 5, 8'd5, 1'b0, 0, 1'b1);
         gap(5);
      end
      chk("seq_trig_cnt", trig_cnt, 32'd3);

      // Backpressure: hold ID 3 for 50 cycles, with a stray trigger pulse in the window.
      CONF_CLK_HALF = 8'd4;
      send_id(15'd3, 1'b0, 4, 8'd4, 1'b0, 0, 1'b0);
      bp_bad = 0;
      p0 = n_pulses;
      for (int c = 0; c < 50; c++) begin
         if (c == 10) TLU_TRIGGER = 1'b1;
         if (c == 14) TLU_TRIGGER = 1'b0;
         step();
         if (!id_valid || !tlu_busy || id_data != 15'd3) bp_bad++;
      end
      chk("bp_hold_errors", bp_bad, 0);
      chk("bp_trig_cnt", trig_cnt, 32'd4);
      chk("bp_no_pulse", n_pulses - p0, 0);
      ID_READY = 1'b1;
      step();
      chk("bp_busy_drop", 32'(tlu_busy), 32'd0);
      chk("bp_valid_drop", 32'(id_valid), 32'd0);
      gap(5);

      // Max ID with clamped half period; CONF change mid-transfer must not matter.
      CONF_CLK_HALF = 8'd2;
      send_id(15'h7FFF, 1'b1, 4, 8'd9, 1'b0, 0, 1'b1);
      chk("max_trig_cnt", trig_cnt, 32'd5);
      gap(5);

      // Disabled trigger is ignored.
      CONF_CLK_HALF = 8'd4;
      ENABLE = 1'b0;
      p0 = n_pulses;
      busy_seen = 0;
      TLU_TRIGGER = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (tlu_busy) busy_seen++;
      end
      TLU_TRIGGER = 1'b0;
      gap(5);
      chk("dis_busy", busy_seen, 0);
      chk("dis_pulse", n_pulses - p0, 0);
      chk("dis_trig_cnt", trig_cnt, 32'd5);
      ENABLE = 1'b1;

      // Expected wrapped to 0 after 0x7FFF; line left high after the transfer.
      send_id(15'd0, 1'b0, 4, 8'd4, 1'b1, 0, 1'b1);
      busy_seen = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (tlu_busy) busy_seen++;
      end
      chk("stuck_high_busy", busy_seen, 0);
      chk("stuck_high_trig_cnt", trig_cnt, 32'd6);
      TLU_TRIGGER = 1'b0;
      gap(5);
      send_id(15'd1, 1'b0, 4, 8'd4, 1'b0, 0, 1'b1);
      chk("rearm_trig_cnt", trig_cnt, 32'd7);
      gap(5);

      // TLU_RESET clears counter and expected ID (expected was 2).
      tlu_reset_pulse();
      chk("tlu_reset2_cnt", trig_cnt, 32'd0);
      send_id(15'd0, 1'b0, 4, 8'd4, 1'b0, 0, 1'b1);
      chk("after_tlu_reset_cnt", trig_cnt, 32'd1);
      gap(5);

      // SYS_RST during the 7th clock pulse, then a normal transfer.
      send_id(15'h0055, 1'b0, 4, 8'd4, 1'b0, 7, 1'b1);
      gap(5);
      send_id(15'h0000, 1'b0, 4, 8'd4, 1'b0, 0, 1'b1);
      chk("after_sysrst_cnt", trig_cnt, 32'd1);
      gap(5);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("polarity_errors", pol_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1);
   end

endmodule
